bpu_check_queue: RTL
====================

Name: bpu_check_queue

Overview:
- Sits between the fetch-side branch predictor and the EX-stage branch unit.
- Buffers each fetched instruction's prediction (pc, pred_pc, pred_taken) in program order until that instruction resolves in EX.
- Compares the stored prediction against the actual outcome and produces the registered fact_pc / fact_tpc / fact_taken / predict_dir_fail / predict_add_fail update bundle consumed by the predictor.
- Produces the front-end redirect on a misprediction.

Parameters:
DEPTH, 8, number of queue entries; must be a power of two, >=2
PTR_W, 3, log2(DEPTH)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
push_valid  in  1  fetch stage enqueues one prediction this cycle
push_pc  in  32  pc of the enqueued instruction
push_pred_pc  in  32  predicted next pc
push_pred_taken  in  2  predictor taken code; 00 = not taken, anything else = taken
full  out  1  queue full; fetch must not push
ex_valid  in  1  one instruction resolves in EX this cycle; pops the head
ex_pc  in  32  pc of the resolving instruction
ex_taken  in  1  actual taken
ex_tpc  in  32  actual target when taken
fact_pc  out  32  registered resolved pc
fact_tpc  out  32  registered actual target
fact_taken  out  1  registered actual direction
predict_dir_fail  out  1  registered direction mispredict
predict_add_fail  out  1  registered target mispredict
redirect_valid  out  1  one-cycle pulse: front end must restart
redirect_pc  out  32  restart pc
order_err  out  1  sticky: head pc did not match ex_pc
count  out  PTR_W+1  current occupancy

Behaviour:
- Reset (async, rst=1) clears:
  - head, tail, count, order_err to 0;
  - all fact_* outputs, fail flags and redirect_valid to 0;
  - redirect_pc to 0.
- Queue structure:
  - circular; head and tail are PTR_W bits wide and wrap modulo DEPTH;
  - full = (count==DEPTH); empty = (count==0).
- Push: accepted when push_valid && (!full || pop_this_cycle); a push while full with no pop is dropped.
- Pop: occurs when ex_valid. Outcome taken from the head entry (pred_t = head.pred_taken!=0).
- Pop on empty: treated as a predicted-not-taken entry with pred_pc = ex_pc+4; count stays 0; order_err is not set.
- order_err: set when a pop finds head.pc != ex_pc. It stays set until reset.
- Compare rules:
  - dir_fail = pred_t != ex_taken;
  - add_fail = pred_t && ex_taken && (head.pred_pc != ex_tpc).
- Latency: all outputs are registered one cycle after the ex_valid cycle:
  - fact_pc = ex_pc, fact_tpc = ex_tpc, fact_taken = ex_taken;
  - fail flags as computed above.
- When ex_valid=0 the next cycle has fact_taken = 0 and both fail flags = 0; fact_pc and fact_tpc hold their previous values.
- Mispredict (dir_fail || add_fail):
  - redirect_valid pulses for exactly one cycle;
  - redirect_pc = ex_taken ? ex_tpc : ex_pc+4 (32-bit wrap);
  - in the same edge head, tail and count are cleared; a push in that same cycle is discarded.
- A push arriving in the cycle redirect_valid is high is accepted normally (first correct-path fetch).
- Simultaneous push and pop with no mispredict: count unchanged; a full queue stays full.

Optional Feature:
- Macro: BPU_CHECK_STAT_EN.
- When defined, adds four 32-bit saturating counters, all reset to 0:
  - stat_br (pops with ex_taken);
  - stat_dir_fail;
  - stat_add_fail;
  - stat_ok (taken and no fail).
- Each counter is exposed as an output port of the same name.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset:
   - stimulus: assert rst mid-run with count=5;
   - response: count=0, full=0, redirect_valid=0, order_err=0 immediately, independent of clk.
2. Correct prediction:
   - stimulus: push pc=0x1C000000, pred_pc=0x1C000040, taken=01; next cycle ex_valid, ex_pc=0x1C000000, ex_taken=1, ex_tpc=0x1C000040;
   - response (+1 cycle): fact_taken=1, both fails 0, redirect_valid=0, count=0.
3. Direction fail:
   - stimulus: push pc=0x100 with taken=00; resolve with ex_taken=1, ex_tpc=0x200;
   - response: predict_dir_fail=1, redirect_valid=1, redirect_pc=0x200, queue emptied (count=0) the next cycle.
4. Target fail:
   - stimulus: push pred_pc=0x300 with taken=10; resolve with ex_tpc=0x340;
   - response: predict_add_fail=1, predict_dir_fail=0, redirect_pc=0x340.
5. Full/wrap:
   - stimulus: 8 pushes, then a 9th push alone;
   - response: 9th push dropped, count=8, full=1.
   - stimulus: 20 cycles of simultaneous push and pop with correct outcomes;
   - response: count stays 8, head/tail wrap, no fails.
6. Order check:
   - stimulus: head pc=0x500, ex_pc=0x504;
   - response: order_err=1 and it stays 1; 50 further correct pops do not clear it.

Source files
------------

// File: rtl/bpu_check_queue.sv
// Branch-prediction check queue: holds fetch-time predictions in program order and scores them at EX resolve.
// Optional BPU_CHECK_STAT_EN adds saturating statistics counters (stat_br, stat_dir_fail, stat_add_fail, stat_ok).
module bpu_check_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic [31:0]      push_pc,
    input  logic [31:0]      push_pred_pc,
    input  logic [1:0]       push_pred_taken,
    output logic             full,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic [31:0]      ex_tpc,
    output logic [31:0]      fact_pc,
    output logic [31:0]      fact_tpc,
    output logic             fact_taken,
    output logic             predict_dir_fail,
    output logic             predict_add_fail,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             order_err,
    output logic [PTR_W:0]   count
`ifdef BPU_CHECK_STAT_EN
    ,
    output logic [31:0]      stat_br,
    output logic [31:0]      stat_dir_fail,
    output logic [31:0]      stat_add_fail,
    output logic [31:0]      stat_ok
`endif
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [31:0]      r_pc_mem  [DEPTH];
    logic [31:0]      r_tgt_mem [DEPTH];
    logic [1:0]       r_tk_mem  [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_pred_t;
    logic [31:0] w_pred_pc;
    logic [31:0] w_pc_plus4;
    logic        w_dir_fail;
    logic        w_add_fail;
    logic        w_mispred;
    logic        w_order_bad;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == DEPTH_C);
    assign w_pc_plus4 = ex_pc + 32'd4;
    assign w_pop      = ex_valid && !w_empty;

    // An EX resolve against an empty queue is scored as a sequential not-taken prediction.
    assign w_pred_t    = w_empty ? 1'b0 : (r_tk_mem[r_head] != 2'b00);
    assign w_pred_pc   = w_empty ? w_pc_plus4 : r_tgt_mem[r_head];
    assign w_dir_fail  = ex_valid && (w_pred_t != ex_taken);
    assign w_add_fail  = ex_valid && w_pred_t && ex_taken && (w_pred_pc != ex_tpc);
    assign w_mispred   = w_dir_fail || w_add_fail;
    assign w_order_bad = w_pop && (r_pc_mem[r_head] != ex_pc);

    // Wrong-path fetch arriving with the mispredict is thrown away along with the flush.
    assign w_push = push_valid && (!w_full || w_pop) && !w_mispred;

    assign full  = w_full;
    assign count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_tail]  <= push_pc;
            r_tgt_mem[r_tail] <= push_pred_pc;
            r_tk_mem[r_tail]  <= push_pred_taken;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            order_err        <= 1'b0;
            fact_pc          <= '0;
            fact_tpc         <= '0;
            fact_taken       <= 1'b0;
            predict_dir_fail <= 1'b0;
            predict_add_fail <= 1'b0;
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
        end else begin
            if (w_mispred) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_pop)  r_head <= r_head + PTR_W'(1);
                if (w_push) r_tail <= r_tail + PTR_W'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                    2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                    default: r_count <= r_count;
                endcase
            end

            if (w_order_bad) order_err <= 1'b1;

            if (ex_valid) begin
                fact_pc  <= ex_pc;
                fact_tpc <= ex_tpc;
            end
            fact_taken       <= ex_valid && ex_taken;
            predict_dir_fail <= w_dir_fail;
            predict_add_fail <= w_add_fail;
            redirect_valid   <= w_mispred;
            if (w_mispred) redirect_pc <= ex_taken ? ex_tpc : w_pc_plus4;
        end
    end

`ifdef BPU_CHECK_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br       <= '0;
            stat_dir_fail <= '0;
            stat_add_fail <= '0;
            stat_ok       <= '0;
        end else begin
            if (ex_valid && ex_taken && (stat_br != '1))      stat_br       <= stat_br + 32'd1;
            if (w_dir_fail && (stat_dir_fail != '1))          stat_dir_fail <= stat_dir_fail + 32'd1;
            if (w_add_fail && (stat_add_fail != '1))          stat_add_fail <= stat_add_fail + 32'd1;
            if (ex_valid && ex_taken && !w_mispred && (stat_ok != '1))
                stat_ok <= stat_ok + 32'd1;
        end
    end
`endif

endmodule
